// File: rtl/arb_pkg.sv
// Shared definitions for the weighted round-robin arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: arbiter FSM state enum and default parameter values.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,  // no owner
    BUSY = 1'b1   // exactly one owner holds the grant
  } arb_state_e;

  localparam int NUM_REQ_DEF  = 4;
  localparam int WEIGHT_W_DEF = 4;

endpackage

// File: rtl/fixed_prio_arb.sv
// Fixed-priority select: the lowest-index asserted request wins.
// Latency: purely combinational.
// Backpressure: none; output follows the request vector directly.
//
// Ports:
//   req_i  [N]  request vector
//   gnt_o  [N]  one-hot (or zero) select of the lowest set bit of req_i
module fixed_prio_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  // Two's-complement trick: x & -x isolates the lowest set bit.
  assign gnt_o = req_i & (~req_i + {{(N-1){1'b0}}, 1'b1});

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: an owner holds the grant for up to
// weight transactions. Latency: grant registered 1 cycle after request.
// Backpressure: ready_i=0 stalls beat counting; owner keeps grant.
//
// Ports:
//   clk, reset     rising-edge clock, async active-low reset
//   req_i          per-requester request level
//   last_i         per-requester final-beat marker (owner's bit only used)
//   weight_i       packed per-requester weights, field k at [k*WEIGHT_W +: WEIGHT_W]
//   ready_i        downstream accepts the owner's beat this cycle
//   gnt_o          registered one-hot grant (or zero)
//   gnt_valid_o    registered |gnt_o
//   gnt_id_o       registered binary owner index, 0 when no grant
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_REQ  = NUM_REQ_DEF,
  parameter  int WEIGHT_W = WEIGHT_W_DEF,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ-1:0]           last_i,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  weight_i,
  input  logic                         ready_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic                         gnt_valid_o,
  output logic [ID_W-1:0]              gnt_id_o
);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 vld_q, vld_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;

  // ---------------------------------------------------------------------
  // Tenure bookkeeping for the current owner
  // ---------------------------------------------------------------------
  logic busy;
  logic owner_req;
  logic done;
  logic release_c;

  assign busy      = (state_q == BUSY);
  assign owner_req = req_i[id_q];
  assign done      = busy && ready_i && last_i[id_q];
  // Release on the last allowed completion, on a completion after the owner
  // has dropped its request, or on an abort (request gone, no beat).
  assign release_c = busy && ((done && ((credit_q == WEIGHT_W'(1)) || !owner_req))
                           || (!owner_req && !ready_i));

  // ---------------------------------------------------------------------
  // Round-robin winner selection
  // ---------------------------------------------------------------------
  // On release the pointer used is the releasing owner's index and the owner
  // is removed from the candidates, so handover happens in the same cycle.
  logic [ID_W-1:0]     arb_ptr;
  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  above_mask;
  logic [NUM_REQ-1:0]  masked_req;
  logic [NUM_REQ-1:0]  masked_gnt;
  logic [NUM_REQ-1:0]  raw_gnt;
  logic [NUM_REQ-1:0]  win_onehot;
  logic [ID_W-1:0]     win_id;
  logic [WEIGHT_W-1:0] win_weight;
  logic [WEIGHT_W-1:0] win_credit;

  always_comb begin
    arb_ptr = ptr_q;
    arb_req = req_i;
    if (release_c) begin
      arb_ptr = id_q;
      arb_req = req_i & ~gnt_q;
    end
  end

  always_comb begin
    above_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      above_mask[i] = (i > int'(arb_ptr));
    end
  end

  assign masked_req = arb_req & above_mask;

  fixed_prio_arb #(.N(NUM_REQ)) u_prio_masked (
    .req_i (masked_req),
    .gnt_o (masked_gnt)
  );

  fixed_prio_arb #(.N(NUM_REQ)) u_prio_raw (
    .req_i (arb_req),
    .gnt_o (raw_gnt)
  );

  // Nothing above the pointer: wrap around to the lowest requester.
  assign win_onehot = (|masked_gnt) ? masked_gnt : raw_gnt;

  always_comb begin
    win_id     = '0;
    win_weight = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) begin
        win_id     = ID_W'(i);
        win_weight = weight_i[i*WEIGHT_W +: WEIGHT_W];
      end
    end
  end

  // A zero weight still grants one transaction.
  assign win_credit = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    vld_d    = vld_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d  = BUSY;
          gnt_d    = win_onehot;
          vld_d    = 1'b1;
          id_d     = win_id;
          credit_d = win_credit;
        end
      end

      BUSY: begin
        if (done && (credit_q != '0)) begin
          credit_d = credit_q - WEIGHT_W'(1);
        end
        if (release_c) begin
          ptr_d = id_q;
          if (|arb_req) begin
            gnt_d    = win_onehot;
            vld_d    = 1'b1;
            id_d     = win_id;
            credit_d = win_credit;
          end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            vld_d    = 1'b0;
            id_d     = '0;
            credit_d = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  // Pointer resets to the top index so requester 0 is first in line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      vld_q    <= 1'b0;
      id_q     <= '0;
      ptr_q    <= ID_W'(NUM_REQ - 1);
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      vld_q    <= vld_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = vld_q;
  assign gnt_id_o    = id_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed scenarios on a 4-requester
// instance with a per-cycle expected-grant queue, plus a long random run
// on a 5-requester instance checking one-hot grant and bounded waiting.
module tb_wrr_arbiter;

  logic        clk;
  logic        reset;

  // 4-requester instance
  logic [3:0]  req;
  logic [3:0]  last;
  logic [15:0] weight;
  logic        ready;
  logic [3:0]  gnt;
  logic        gnt_vld;
  logic [1:0]  gnt_id;

  // 5-requester instance
  logic [4:0]  req5;
  logic [4:0]  last5;
  logic [19:0] weight5;
  logic        ready5;
  logic [4:0]  gnt5;
  logic        gnt_vld5;
  logic [2:0]  gnt_id5;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] id;
  } exp_t;

  exp_t exp_q[$];

  wrr_arbiter u_dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
    .last_i      (last),
    .weight_i    (weight),
    .ready_i     (ready),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_vld),
    .gnt_id_o    (gnt_id)
  );

  wrr_arbiter #(.NUM_REQ(5), .WEIGHT_W(4)) u_dut5 (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req5),
    .last_i      (last5),
    .weight_i    (weight5),
    .ready_i     (ready5),
    .gnt_o       (gnt5),
    .gnt_valid_o (gnt_vld5),
    .gnt_id_o    (gnt_id5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push_exp(input logic v, input logic [1:0] id);
    exp_t e;
    e.vld = v;
    e.id  = v ? id : 2'd0;
    e.gnt = v ? (4'b0001 << id) : 4'b0000;
    exp_q.push_back(e);
  endfunction

  task automatic do_reset();
    reset   = 1'b0;
    req     = '0;
    last    = '0;
    weight  = '0;
    ready   = 1'b0;
    req5    = '0;
    last5   = '0;
    weight5 = '0;
    ready5  = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    req = '0; last = '0; weight = '0; ready = 1'b0;
    req5 = '0; last5 = '0; weight5 = '0; ready5 = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0 || gnt_vld !== 1'b0 || gnt_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_hold: gnt=%b vld=%b id=%0d, want 0000/0/0", gnt, gnt_vld, gnt_id);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    // No requests: stays idle for two edges.
    push_exp(1'b0, 2'd0);
    push_exp(1'b0, 2'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.gnt || gnt_vld !== e.vld || gnt_id !== e.id) begin
        failures++;
        $display("FAIL reset_idle c%0d: gnt=%b vld=%b id=%0d, want %b/%b/%0d",
                 c, gnt, gnt_vld, gnt_id, e.gnt, e.vld, e.id);
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [1:0] ids[5];
    ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    weight = 16'h1111;
    ready  = 1'b1;
    last   = 4'hF;
    req    = 4'hF;
    for (int c = 0; c < 5; c++) push_exp(1'b1, ids[c]);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.gnt || gnt_vld !== e.vld || gnt_id !== e.id) begin
        failures++;
        $display("FAIL round_robin c%0d: gnt=%b vld=%b id=%0d, want %b/%b/%0d",
                 c, gnt, gnt_vld, gnt_id, e.gnt, e.vld, e.id);
      end
    end
  endtask

  task automatic test_weighted();
    exp_t e;
    logic [1:0] ids[5];
    ids = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    do_reset();
    weight = 16'h1131;  // requester 1 weight 3, others 1
    ready  = 1'b1;
    last   = 4'hF;
    req    = 4'b0011;
    for (int c = 0; c < 5; c++) push_exp(1'b1, ids[c]);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.gnt || gnt_vld !== e.vld || gnt_id !== e.id) begin
        failures++;
        $display("FAIL weighted c%0d: gnt=%b vld=%b id=%0d, want %b/%b/%0d",
                 c, gnt, gnt_vld, gnt_id, e.gnt, e.vld, e.id);
      end
    end
  endtask

  task automatic test_abort();
    exp_t e;
    logic [3:0] stim[3];
    stim = '{4'b0100, 4'b1000, 4'b1011};
    do_reset();
    weight = 16'h1111;
    ready  = 1'b0;
    last   = 4'h0;
    push_exp(1'b1, 2'd2);
    push_exp(1'b1, 2'd3);
    push_exp(1'b1, 2'd3);  // owner 3 keeps grant despite new requests
    for (int c = 0; c < 3; c++) begin
      req = stim[c];
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.gnt || gnt_vld !== e.vld || gnt_id !== e.id) begin
        failures++;
        $display("FAIL abort c%0d: gnt=%b vld=%b id=%0d, want %b/%b/%0d",
                 c, gnt, gnt_vld, gnt_id, e.gnt, e.vld, e.id);
      end
      if (c == 1) begin
        checks++;
        if (u_dut.ptr_q !== 2'd2) begin
          failures++;
          $display("FAIL abort_ptr: ptr=%0d, want 2", u_dut.ptr_q);
        end
      end
    end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    weight = 16'h1121;  // requester 1 weight 2
    ready  = 1'b1;
    last   = 4'hF;
    req    = 4'b0010;
    push_exp(1'b1, 2'd1);
    push_exp(1'b1, 2'd1);
    push_exp(1'b0, 2'd0);
    push_exp(1'b1, 2'd1);
    push_exp(1'b1, 2'd1);
    push_exp(1'b0, 2'd0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.gnt || gnt_vld !== e.vld || gnt_id !== e.id) begin
        failures++;
        $display("FAIL single c%0d: gnt=%b vld=%b id=%0d, want %b/%b/%0d",
                 c, gnt, gnt_vld, gnt_id, e.gnt, e.vld, e.id);
      end
    end
  endtask

  task automatic test_weight_zero();
    exp_t e;
    do_reset();
    weight = 16'h0000;  // zero weight behaves as one
    ready  = 1'b1;
    last   = 4'hF;
    req    = 4'b0001;
    push_exp(1'b1, 2'd0);
    push_exp(1'b0, 2'd0);
    push_exp(1'b1, 2'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.gnt || gnt_vld !== e.vld || gnt_id !== e.id) begin
        failures++;
        $display("FAIL weight_zero c%0d: gnt=%b vld=%b id=%0d, want %b/%b/%0d",
                 c, gnt, gnt_vld, gnt_id, e.gnt, e.vld, e.id);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    do_reset();
    weight = 16'h1111;
    ready  = 1'b0;
    last   = 4'h0;
    req    = 4'b1000;
    push_exp(1'b1, 2'd3);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (gnt !== e.gnt || gnt_vld !== e.vld || gnt_id !== e.id) begin
      failures++;
      $display("FAIL async_pre: gnt=%b vld=%b id=%0d, want %b/%b/%0d",
               gnt, gnt_vld, gnt_id, e.gnt, e.vld, e.id);
    end
    #2;
    reset = 1'b0;  // between clock edges
    #1;
    checks++;
    if (gnt !== 4'b0 || gnt_vld !== 1'b0 || gnt_id !== 2'd0) begin
      failures++;
      $display("FAIL async_clear: gnt=%b vld=%b id=%0d, want 0000/0/0", gnt, gnt_vld, gnt_id);
    end
    req = 4'b0110;
    @(negedge clk);
    reset = 1'b1;
    push_exp(1'b1, 2'd1);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (gnt !== e.gnt || gnt_vld !== e.vld || gnt_id !== e.id) begin
      failures++;
      $display("FAIL async_first: gnt=%b vld=%b id=%0d, want %b/%b/%0d",
               gnt, gnt_vld, gnt_id, e.gnt, e.vld, e.id);
    end
  endtask

  task automatic test_random();
    int         wcnt[5];
    logic       prev_vld;
    logic [2:0] prev_id;
    logic       new_ten;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      weight5[k*4 +: 4] = 4'($urandom_range(0, 3));
      wcnt[k] = 0;
    end
    prev_vld = 1'b0;
    prev_id  = 3'd0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      checks++;
      if ($countones(gnt5) > 1 || gnt_vld5 !== (|gnt5) ||
          (gnt_vld5 && gnt5 !== (5'd1 << gnt_id5)) ||
          (!gnt_vld5 && gnt_id5 !== 3'd0)) begin
        failures++;
        $display("FAIL rand_onehot c%0d: gnt=%b vld=%b id=%0d", c, gnt5, gnt_vld5, gnt_id5);
      end
      // req5 still holds the value sampled at this edge.
      new_ten = gnt_vld5 && (!prev_vld || gnt_id5 != prev_id);
      for (int k = 0; k < 5; k++) begin
        if (!req5[k] || (gnt_vld5 && gnt_id5 == 3'(k))) begin
          wcnt[k] = 0;
        end else if (new_ten) begin
          wcnt[k]++;
          checks++;
          if (wcnt[k] > 4) begin
            failures++;
            $display("FAIL rand_starve c%0d: req %0d waited %0d tenures, max 4", c, k, wcnt[k]);
          end
        end
      end
      prev_vld = gnt_vld5;
      prev_id  = gnt_id5;
      for (int k = 0; k < 5; k++) begin
        if (req5[k]) req5[k] = ($urandom_range(0, 9) != 0);
        else         req5[k] = ($urandom_range(0, 3) == 0);
      end
      ready5 = ($urandom_range(0, 3) != 0);
      last5  = 5'($urandom);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_round_robin();
    test_weighted();
    test_abort();
    test_single();
    test_weight_zero();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
